fmap_capture_mc: RTL



---
 rtl/fmap_capture_mc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fmap_capture_mc.sv
// Multi-channel feature-map capture: converts signed column beats to saturated
// pixels and writes them one per clock into per-channel regions of a display BRAM.
module fmap_capture_mc #(
    parameter  int PIX_W     = 24,
    parameter  int PIX_H     = 24,
    parameter  int N_CH      = 4,
    parameter  int DATA_W    = 24,
    parameter  int PIX_BITS  = 8,
    parameter  int ADDR_W    = 16,
    parameter  int BASE_ADDR = 0,
    localparam int SH_W      = $clog2(DATA_W),
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_col,
    output logic                          ready_col,
    input  logic [PIX_H-1:0][DATA_W-1:0]  data_col,
    input  logic [SH_W-1:0]               cfg_shift,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic [PIX_BITS-1:0]           bram_wdata,
    output logic                          bram_we,
    output logic                          busy,
    output logic                          map_done,
    output logic [CH_W-1:0]               map_ch,
    output logic                          frame_done
);

    localparam int COL_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int ROW_W = (PIX_H > 1) ? $clog2(PIX_H) : 1;
    localparam logic signed [DATA_W-1:0] PIX_MAX = DATA_W'((1 << PIX_BITS) - 1);

    if (64'(BASE_ADDR) + 64'(N_CH) * 64'(PIX_W) * 64'(PIX_H) > (64'd1 << ADDR_W)) begin : g_addr_check
        $error("fmap_capture_mc: channel regions do not fit in ADDR_W address space");
    end

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                   state_reg;
    logic [ROW_W-1:0]         row_reg;
    logic [1:0]               count_reg;
    logic                     wr_ptr_reg;
    logic                     rd_ptr_reg;
    logic [COL_W-1:0]         d_col_reg;
    logic [CH_W-1:0]          d_ch_reg;
    logic [COL_W-1:0]         a_col_reg;
    logic [CH_W-1:0]          a_ch_reg;
    logic [SH_W-1:0]          shift_reg;
    logic                     ready_reg;
    logic [ADDR_W-1:0]        addr_reg;
    logic [PIX_BITS-1:0]      wdata_reg;
    logic                     map_done_reg;
    logic [CH_W-1:0]          map_ch_reg;
    logic                     frame_done_reg;

    logic [PIX_BITS-1:0]      col_buf [2][PIX_H];

    logic                     accept;
    logic                     first_beat;
    logic [SH_W-1:0]          shift_use;
    logic [PIX_H-1:0][PIX_BITS-1:0] conv_pix;

    logic                     finishing;
    logic [1:0]               count_next;
    logic                     rd_ptr_next;
    logic [COL_W-1:0]         d_col_next;
    logic [CH_W-1:0]          d_ch_next;
    logic                     emit;
    logic [ROW_W-1:0]         emit_row;
    logic [PIX_BITS-1:0]      emit_pix;
    logic [31:0]              emit_addr_wide;
    logic                     emit_last;

    assign ready_col  = ready_reg && !rst;
    assign accept     = valid_col && ready_col;
    assign first_beat = (a_col_reg == '0) && (a_ch_reg == '0);
    assign shift_use  = first_beat ? cfg_shift : shift_reg;

    for (genvar gi = 0; gi < PIX_H; gi++) begin : g_conv
        logic signed [DATA_W-1:0] shifted;
        assign shifted      = $signed(data_col[gi]) >>> shift_use;
        assign conv_pix[gi] = shifted[DATA_W-1]  ? '0 :
                              (shifted > PIX_MAX) ? '1 : shifted[PIX_BITS-1:0];
    end

    // The output stage is one clock ahead of storage: a column accepted into an
    // empty engine is emitted straight from the converter for its row 0.
    always_comb begin
        finishing   = (state_reg == DRAIN) && (row_reg == ROW_W'(PIX_H - 1));
        count_next  = count_reg + {1'b0, accept} - {1'b0, finishing};
        rd_ptr_next = rd_ptr_reg;
        d_col_next  = d_col_reg;
        d_ch_next   = d_ch_reg;
        if (finishing) begin
            rd_ptr_next = ~rd_ptr_reg;
            if (d_col_reg == COL_W'(PIX_W - 1)) begin
                d_col_next = '0;
                d_ch_next  = (d_ch_reg == CH_W'(N_CH - 1)) ? '0 : d_ch_reg + 1'b1;
            end else begin
                d_col_next = d_col_reg + 1'b1;
            end
        end

        emit     = 1'b0;
        emit_row = '0;
        emit_pix = '0;
        if ((state_reg == DRAIN) && !finishing) begin
            emit     = 1'b1;
            emit_row = row_reg + 1'b1;
            emit_pix = col_buf[rd_ptr_reg][emit_row];
        end else if ((count_reg == 2'd2) || ((count_reg == 2'd1) && !finishing)) begin
            emit     = 1'b1;
            emit_pix = col_buf[rd_ptr_next][0];
        end else if (accept) begin
            emit     = 1'b1;
            emit_pix = conv_pix[0];
        end

        emit_addr_wide = 32'(BASE_ADDR) + 32'(d_ch_next) * 32'(PIX_W * PIX_H)
                       + 32'(emit_row) * 32'(PIX_W) + 32'(d_col_next);
        emit_last      = emit && (emit_row == ROW_W'(PIX_H - 1))
                       && (d_col_next == COL_W'(PIX_W - 1));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < PIX_H; r++) begin
                col_buf[wr_ptr_reg][r] <= conv_pix[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            count_reg      <= '0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            d_col_reg      <= '0;
            d_ch_reg       <= '0;
            a_col_reg      <= '0;
            a_ch_reg       <= '0;
            shift_reg      <= '0;
            ready_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            map_done_reg   <= 1'b0;
            map_ch_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= emit ? DRAIN : IDLE;
            count_reg      <= count_next;
            ready_reg      <= (count_next < 2'd2);
            rd_ptr_reg     <= rd_ptr_next;
            d_col_reg      <= d_col_next;
            d_ch_reg       <= d_ch_next;
            map_done_reg   <= emit_last;
            frame_done_reg <= emit_last && (d_ch_next == CH_W'(N_CH - 1));
            if (emit) begin
                row_reg   <= emit_row;
                addr_reg  <= emit_addr_wide[ADDR_W-1:0];
                wdata_reg <= emit_pix;
            end
            if (emit_last) begin
                map_ch_reg <= d_ch_next;
            end
            if (accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
                if (first_beat) begin
                    shift_reg <= cfg_shift;
                end
                if (a_col_reg == COL_W'(PIX_W - 1)) begin
                    a_col_reg <= '0;
                    a_ch_reg  <= (a_ch_reg == CH_W'(N_CH - 1)) ? '0 : a_ch_reg + 1'b1;
                end else begin
                    a_col_reg <= a_col_reg + 1'b1;
                end
            end
        end
    end

    assign bram_we    = (state_reg == DRAIN);
    assign bram_addr  = addr_reg;
    assign bram_wdata = wdata_reg;
    assign busy       = (count_reg != 2'd0) || (state_reg == DRAIN);
    assign map_done   = map_done_reg;
    assign map_ch     = map_ch_reg;
    assign frame_done = frame_done_reg;

endmodule
